stopwatch_ctrl: RTL
===================

# stopwatch_ctrl

Control sequencer for the digital stopwatch on Basys3.
- Cleans up the raw start/stop and reset push-buttons.
- Runs the IDLE/RUNNING/PAUSED state machine.
- Produces the run enable, a one-cycle clear pulse and a prescaled count tick that drive the stopwatch tick counter.
- Sits between the board buttons and the counter/display datapath.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable cycles required before a button level is accepted (10 ms at 100 MHz).
- `TICK_DIV`, default 1_000_000: clk cycles per count tick while running (100 Hz at 100 MHz); must be ≥ 2.
- `clk` input 1: system clock, 100 MHz.
- `reset` input 1: synchronous, active-high reset.
- `btn_start_stop` input 1: raw, asynchronous start/stop button.
- `btn_reset` input 1: raw, asynchronous stopwatch-clear button.
- `btn_lap` input 1: raw lap button. Present only with `STOPWATCH_LAP_EN`.
- `run` output 1: high while in RUNNING.
- `tick` output 1: one-cycle count-enable pulse to the counter.
- `clr` output 1: one-cycle pulse to clear the counter.
- `state` output 2: current state (IDLE=0, RUNNING=1, PAUSED=2).
- `hold` output 1: freezes the display latch. Present only with `STOPWATCH_LAP_EN`.

## Operation
- **Button conditioning.** Each button passes through:
  - a 2-FF synchronizer, then
  - a debouncer, whose output level toggles only after the synchronized input differs from it for `DEBOUNCE_CYCLES` consecutive cycles (a mismatch counter, cleared on any match), then
  - rising-edge detection, producing a registered `press = db & ~db_q`.
- **State machine transitions.** Evaluated on presses:
  - IDLE + start_stop press → RUNNING.
  - RUNNING + start_stop press → PAUSED.
  - PAUSED + start_stop press → RUNNING.
  - reset press in any state → IDLE, with `clr`=1 for exactly one cycle.
  - Reset press and start_stop press in the same cycle: reset press wins, start_stop press is dropped.
  - Reset press while already in IDLE still pulses `clr`.
- **Prescaler.** Width `$clog2(TICK_DIV)`.
  - In RUNNING it counts 0..`TICK_DIV`-1 and wraps to 0.
  - `tick`=1 in the cycle where count == `TICK_DIV`-1.
  - In PAUSED it holds its value. Resuming continues from that value, so no partial tick is lost or repeated.
  - Cleared to 0 on entry to IDLE.
  - `tick` is never asserted outside RUNNING.
- **Outputs.** `run` and `state` are registered and decoded from the state register.

## Timing
- **After `reset`:**
  - state = IDLE.
  - `run`, `tick`, `clr`, `hold` all = 0.
  - Sync FFs, debounced levels, edge registers and all counters = 0.
- **Press latency.** From a raw level change held stable to the state change:
  - 2 cycles of synchronizer,
  - `DEBOUNCE_CYCLES` to debounce,
  - 1 cycle for the `press` register,
  - 1 cycle for the state register.
- **Release.** Release is debounced identically and never produces a press.
- **Bounces** shorter than `DEBOUNCE_CYCLES` produce no press.
- **`clr` timing.** Asserted in the same cycle state first reads IDLE after a reset press.
- **First tick after IDLE→RUNNING.** Asserted on the `TICK_DIV`-th cycle with `run`=1.
- **`reset` mid-debounce or mid-count** aborts everything; no press or tick is emitted on the following cycle.

## Configuration
- **`STOPWATCH_LAP_EN` defined:**
  - Adds `btn_lap` (same conditioning chain) and `hold`.
  - In RUNNING, a lap press toggles `hold`.
  - Entering PAUSED or IDLE forces `hold`=0.
  - Counting and `tick` are unaffected by `hold`.
  - Reset press wins over lap press in the same cycle.
- **Not defined:** no `btn_lap` or `hold` ports and no lap logic.

## Structure
- **Shared package `stopwatch_pkg`:**
  - `sw_state_t` enum (IDLE, RUNNING, PAUSED; 2 bits).
  - Default constants `SW_DEBOUNCE_CYCLES` and `SW_TICK_DIV`.
  - The counter and display blocks import the same package.
- **Sub-module `button_debounce`** (parameter `DEBOUNCE_CYCLES`; ports `clk`, `reset`, `btn_in`, `level`, `press`): synchronizer, debouncer and edge detector. Instantiated once per button.

## Test plan
Bench uses `DEBOUNCE_CYCLES`=4 and `TICK_DIV`=5.
- **Clean start.** `reset` high for 2 cycles, then hold `btn_start_stop` high for 10 cycles → `run` rises 8 cycles after the input rises (2 + 4 + 1 + 1). Then `tick` pulses every 5 cycles, first on the 5th `run` cycle.
- **Bounce rejection.** Toggle `btn_start_stop` 1-0-1-0 with 3-cycle pulses → no press; state stays IDLE, `tick` stays 0.
- **Pause/resume.**
  - Pause when the prescaler is at 2: hold 20 cycles → no `tick`, prescaler holds at 2.
  - Resume: hold `btn_start_stop` high until `run` rises (8 cycles after the input rises) → next `tick` exactly 3 `run` cycles later.
- **Simultaneous press.** Both buttons pressed in the same cycle from RUNNING → state IDLE, `clr`=1 for 1 cycle, `run`=0, prescaler 0.
- **Mid-operation reset.** Assert `reset` while RUNNING with the debounce counter at 2 → next cycle state IDLE, all outputs 0, no press emitted.
- **Lap toggle (`STOPWATCH_LAP_EN`).** Lap press in RUNNING → `hold`=1, `tick` continues. Second lap press → `hold`=0. Lap press then start_stop press → PAUSED with `hold`=0.

Source files
------------

// File: rtl/stopwatch_ctrl_pkg.sv
// Shared stopwatch types, default timing constants and the FSM transition function.
// Imported by stopwatch_ctrl, button_debounce and the counter/display blocks.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUNNING = 2'd1,
      PAUSED  = 2'd2
   } sw_state_t;

   localparam int SW_DEBOUNCE_CYCLES = 1_000_000;
   localparam int SW_TICK_DIV        = 1_000_000;

   // A clear press overrides a start/stop press arriving in the same cycle.
   function automatic sw_state_t sw_next_state(sw_state_t cur, logic ss_press, logic clr_press);
      sw_state_t nxt;
      nxt = cur;
      if (clr_press) begin
         nxt = IDLE;
      end else if (ss_press) begin
         case (cur)
            IDLE, PAUSED: nxt = RUNNING;
            RUNNING:      nxt = PAUSED;
            default:      nxt = IDLE;
         endcase
      end
      return nxt;
   endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button inputs and counter-control outputs of the stopwatch sequencer.
// STOPWATCH_LAP_EN adds the lap button and the display hold output.
interface stopwatch_ctrl_if;
   logic       btn_start_stop;
   logic       btn_reset;
   logic       run;
   logic       tick;
   logic       clr;
   logic [1:0] state;
`ifdef STOPWATCH_LAP_EN
   logic       btn_lap;
   logic       hold;

   modport master (input btn_start_stop, btn_reset, btn_lap,
                   output run, tick, clr, state, hold);
   modport slave  (output btn_start_stop, btn_reset, btn_lap,
                   input run, tick, clr, state, hold);
`else
   modport master (input btn_start_stop, btn_reset,
                   output run, tick, clr, state);
   modport slave  (output btn_start_stop, btn_reset,
                   input run, tick, clr, state);
`endif
endinterface

// File: rtl/stopwatch_ctrl_debounce.sv
// button_debounce: 2-FF synchronizer, mismatch-count debouncer and registered
// rising-edge detector for one raw push-button.
module button_debounce
   import stopwatch_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_in,
   output logic level,
   output logic press
);
   localparam int             CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q, sync2_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             level_q, level_d;
   logic             level_prev_q;
   logic             press_q;

   // Level flips on the DEBOUNCE_CYCLES-th consecutive mismatch; any match restarts the count.
   always_comb begin
      cnt_d   = cnt_q;
      level_d = level_q;
      if (sync2_q == level_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
         cnt_d   = '0;
         level_d = sync2_q;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q      <= 1'b0;
         sync2_q      <= 1'b0;
         cnt_q        <= '0;
         level_q      <= 1'b0;
         level_prev_q <= 1'b0;
         press_q      <= 1'b0;
      end else begin
         sync1_q      <= btn_in;
         sync2_q      <= sync1_q;
         cnt_q        <= cnt_d;
         level_q      <= level_d;
         level_prev_q <= level_q;
         press_q      <= level_q & ~level_prev_q;
      end
   end

   assign level = level_q;
   assign press = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: button conditioning, IDLE/RUNNING/PAUSED FSM and
// count-tick prescaler. Optional lap/hold logic under STOPWATCH_LAP_EN.
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE_CYCLES,
   parameter int TICK_DIV        = SW_TICK_DIV
) (
   input logic              clk,
   input logic              reset,
   stopwatch_ctrl_if.master sw
);
   localparam int               PRE_W   = $clog2(TICK_DIV);
   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

   logic ss_level, ss_press;
   logic rst_level, rst_press;
   logic unused_levels;

   sw_state_t        state_q, state_d;
   logic             run_q;
   logic             clr_q;
   logic [PRE_W-1:0] pre_q, pre_d;

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_ss (
      .clk(clk), .reset(reset), .btn_in(sw.btn_start_stop), .level(ss_level), .press(ss_press)
   );

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_rst (
      .clk(clk), .reset(reset), .btn_in(sw.btn_reset), .level(rst_level), .press(rst_press)
   );

`ifdef STOPWATCH_LAP_EN
   logic lap_level, lap_press;
   logic hold_q;

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lap (
      .clk(clk), .reset(reset), .btn_in(sw.btn_lap), .level(lap_level), .press(lap_press)
   );

   assign unused_levels = ^{ss_level, rst_level, lap_level};
   assign sw.hold       = hold_q;
`else
   assign unused_levels = ^{ss_level, rst_level};
`endif

   // Prescaler freezes in PAUSED so a resume neither loses nor repeats a partial tick.
   always_comb begin
      state_d = sw_next_state(state_q, ss_press, rst_press);
      pre_d   = pre_q;
      if (state_d == IDLE) begin
         pre_d = '0;
      end else if (state_q == RUNNING) begin
         pre_d = (pre_q == PRE_MAX) ? '0 : pre_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         run_q   <= 1'b0;
         clr_q   <= 1'b0;
         pre_q   <= '0;
`ifdef STOPWATCH_LAP_EN
         hold_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         run_q   <= (state_d == RUNNING);
         clr_q   <= rst_press;
         pre_q   <= pre_d;
`ifdef STOPWATCH_LAP_EN
         if (state_d != RUNNING) begin
            hold_q <= 1'b0;
         end else if ((state_q == RUNNING) && lap_press) begin
            hold_q <= ~hold_q;
         end
`endif
      end
   end

   assign sw.run   = run_q;
   assign sw.clr   = clr_q;
   assign sw.state = state_q;
   assign sw.tick  = run_q & (pre_q == PRE_MAX);

endmodule
